// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor: diff = a - b - bin, LSB-first, one bit per
// cycle through a single borrow cell, with val/rdy streams on both sides.

module sub_serial_cell (
   input  logic x,
   input  logic y,
   input  logic w,
   output logic d,
   output logic bo
);
   // Full-subtractor: borrow when x < y + w for this bit.
   assign d  = x ^ y ^ w;
   assign bo = (~x & y) | (~(x ^ y) & w);
endmodule

module sub_serial #(
   parameter int nbits = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             istream_val,
   output logic             istream_rdy,
   input  logic [nbits-1:0] a,
   input  logic [nbits-1:0] b,
   input  logic             bin,
   output logic             ostream_val,
   input  logic             ostream_rdy,
   output logic [nbits-1:0] diff,
   output logic             bout,
   output logic             zero
);
   localparam int CW = (nbits > 1) ? $clog2(nbits) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [nbits-1:0] a_sh, b_sh, diff_r, diff_shift;
   logic             borrow;
   logic             d, bo_nxt, last;

   sub_serial_cell u_cell (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .w  (borrow),
      .d  (d),
      .bo (bo_nxt)
   );

   assign last = (cnt == CW'(nbits - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      istream_rdy = 1'b0;
      ostream_val = 1'b0;
      case (state)
         IDLE: begin
            istream_rdy = 1'b1;
            if (istream_val) state_nxt = CALC;
         end
         CALC: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            ostream_val = 1'b1;
            if (ostream_rdy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // New result bit enters at the MSB; after nbits shifts bit 0 sits at the LSB.
   always_comb begin
      diff_shift            = diff_r >> 1;
      diff_shift[nbits-1]   = d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         diff_r <= '0;
         borrow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (istream_val) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  borrow <= bin;
                  cnt    <= '0;
               end
            end
            CALC: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               diff_r <= diff_shift;
               borrow <= bo_nxt;
               if (!last) cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign diff = diff_r;
   assign bout = borrow;
   assign zero = ~|diff_r;

endmodule

// File: tb/tb_sub_serial.sv
// Directed bench for sub_serial at nbits = 1, 8 and 16 sharing one clock/reset.

module tb_sub_serial;
   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  ival, ordy;
   logic [15:0] a_in, b_in;
   logic        bin_in;

   logic [2:0]  irdy, ovld, bo, zr;
   logic [0:0]  dif1;
   logic [7:0]  dif8;
   logic [15:0] dif16;
   logic [15:0] dif [3];

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   sub_serial #(.nbits(1)) u1 (
      .clk(clk), .reset(reset), .istream_val(ival[0]), .istream_rdy(irdy[0]),
      .a(a_in[0:0]), .b(b_in[0:0]), .bin(bin_in), .ostream_val(ovld[0]),
      .ostream_rdy(ordy[0]), .diff(dif1), .bout(bo[0]), .zero(zr[0])
   );
   sub_serial #(.nbits(8)) u8 (
      .clk(clk), .reset(reset), .istream_val(ival[1]), .istream_rdy(irdy[1]),
      .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin_in), .ostream_val(ovld[1]),
      .ostream_rdy(ordy[1]), .diff(dif8), .bout(bo[1]), .zero(zr[1])
   );
   sub_serial #(.nbits(16)) u16 (
      .clk(clk), .reset(reset), .istream_val(ival[2]), .istream_rdy(irdy[2]),
      .a(a_in), .b(b_in), .bin(bin_in), .ostream_val(ovld[2]),
      .ostream_rdy(ordy[2]), .diff(dif16), .bout(bo[2]), .zero(zr[2])
   );

   assign dif[0] = {15'd0, dif1};
   assign dif[1] = {8'd0, dif8};
   assign dif[2] = dif16;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full transaction on one instance: accept, latency window, result, handshake.
   task automatic run_op(input int sel, input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic bi, input logic [15:0] ed, input logic eb, input string tag);
      chk({tag, "_in_rdy"}, irdy[sel], 1'b1);
      a_in = a; b_in = b; bin_in = bi; ival[sel] = 1'b1;
      tick();
      ival[sel] = 1'b0;
      a_in = '0; b_in = '0; bin_in = 1'b0;
      for (int k = 0; k < w; k++) begin
         chk({tag, "_busy"}, {irdy[sel], ovld[sel]}, 2'b00);
         tick();
      end
      chk({tag, "_oval"}, ovld[sel], 1'b1);
      chk({tag, "_diff"}, dif[sel], ed);
      chk({tag, "_bout"}, bo[sel], eb);
      chk({tag, "_zero"}, zr[sel], (ed == 16'd0));
      ordy[sel] = 1'b1;
      tick();
      ordy[sel] = 1'b0;
      chk({tag, "_post"}, {irdy[sel], ovld[sel]}, 2'b10);
   endtask

   initial begin
      logic [7:0]  td, tbo;
      logic [2:0]  idx;
      logic [16:0] gold;
      logic [15:0] ra, rb;
      logic        rbi;

      reset = 1'b1; ival = '0; ordy = '0; a_in = '0; b_in = '0; bin_in = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();

      for (int s = 0; s < 3; s++) begin
         chk("rst_in_rdy", irdy[s], 1'b1);
         chk("rst_oval",   ovld[s], 1'b0);
         chk("rst_diff",   dif[s],  16'd0);
         chk("rst_bout",   bo[s],   1'b0);
         chk("rst_zero",   zr[s],   1'b1);
      end

      // ostream_rdy held high while idle must not matter.
      ordy[1] = 1'b1; tick(); ordy[1] = 1'b0;
      chk("idle_ordy", {irdy[1], ovld[1]}, 2'b10);

      run_op(1, 8, 16'h35, 16'h12, 1'b0, 16'h23, 1'b0, "t1");
      run_op(1, 8, 16'h00, 16'h01, 1'b0, 16'hFF, 1'b1, "t2_wrap");
      run_op(1, 8, 16'h10, 16'h0F, 1'b1, 16'h00, 1'b0, "t3_zero");
      run_op(1, 8, 16'h00, 16'hFF, 1'b1, 16'h00, 1'b1, "t3_bzero");

      // Backpressure: 0x55 - 0x05 = 0x50 held in DONE for 5 cycles.
      a_in = 16'h55; b_in = 16'h05; bin_in = 1'b0; ival[1] = 1'b1;
      tick();
      ival[1] = 1'b0;
      repeat (8) tick();
      for (int k = 0; k < 5; k++) begin
         chk("bp_oval",   ovld[1], 1'b1);
         chk("bp_in_rdy", irdy[1], 1'b0);
         chk("bp_diff",   dif[1],  16'h50);
         chk("bp_bout",   bo[1],   1'b0);
         chk("bp_zero",   zr[1],   1'b0);
         if (k == 1) begin
            a_in = 16'hAA; b_in = 16'h00; ival[1] = 1'b1;
         end else begin
            ival[1] = 1'b0;
         end
         tick();
      end
      ival[1] = 1'b0;
      ordy[1] = 1'b1;
      tick();
      ordy[1] = 1'b0;
      chk("bp_release", {irdy[1], ovld[1]}, 2'b10);
      tick();
      chk("bp_no_capture", {irdy[1], ovld[1]}, 2'b10);

      // Reset in the 4th CALC cycle discards the op.
      a_in = 16'h33; b_in = 16'h11; bin_in = 1'b0; ival[1] = 1'b1;
      tick();
      ival[1] = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_calc_idle", {irdy[1], ovld[1]}, 2'b10);
      for (int k = 0; k < 10; k++) begin
         chk("rst_calc_noval", ovld[1], 1'b0);
         tick();
      end
      run_op(1, 8, 16'h80, 16'h01, 1'b0, 16'h7F, 1'b0, "t5_after_rst");

      // nbits=1 truth table, indexed by {a,b,bin}.
      td  = 8'b1001_0110;
      tbo = 8'b1000_1110;
      for (int i = 0; i < 8; i++) begin
         idx = 3'(i);
         run_op(0, 1, {15'd0, idx[2]}, {15'd0, idx[1]}, idx[0],
                {15'd0, td[idx]}, tbo[idx], "t6_bit");
      end

      // Random sweep at nbits=16 against a - b - bin.
      for (int i = 0; i < 1000; i++) begin
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         rbi  = 1'($urandom);
         if (i == 0) begin ra = 16'hFFFF; rb = 16'h0000; rbi = 1'b0; end
         if (i == 1) begin ra = 16'h0000; rb = 16'hFFFF; rbi = 1'b1; end
         gold = {1'b0, ra} - {1'b0, rb} - {16'd0, rbi};
         run_op(2, 16, ra, rb, rbi, gold[15:0], gold[16], "t6_rand16");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
